// File: rtl/adder_sequencer_pkg.sv
// adder_sequencer_pkg
// Shared constants and types for the word-serial adder sequencer.
//   WORD_W_DEF / WORDS_DEF : default pass width and passes per operation
//   seq_state_t            : sequencer FSM state encoding
//   index_width()          : width of a counter able to hold 0..words-1
package adder_sequencer_pkg;

   localparam int WORD_W_DEF = 32;
   localparam int WORDS_DEF  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   // A single-word configuration still needs a 1-bit counter to stay legal.
   function automatic int index_width(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/adder_sequencer_if.sv
// adder_sequencer_if
// Bus between the sequencer and the external shared word adder.
//   add_a, add_b : operand words presented to the adder
//   add_cin      : carry-in presented to the adder
//   add_sum      : combinational sum returned by the adder
//   add_cout     : combinational carry-out returned by the adder
// Modports: master = sequencer side, slave = adder side.
interface adder_sequencer_if
   import adder_sequencer_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF
);

   logic [WORD_W-1:0] add_a;
   logic [WORD_W-1:0] add_b;
   logic              add_cin;
   logic [WORD_W-1:0] add_sum;
   logic              add_cout;

   modport master (
      output add_a, add_b, add_cin,
      input  add_sum, add_cout
   );

   modport slave (
      input  add_a, add_b, add_cin,
      output add_sum, add_cout
   );

endinterface

// File: rtl/adder_sequencer.sv
// adder_sequencer
// Performs an N-bit add or subtract (N = WORD_W*WORDS) by feeding one word
// per cycle, LSW first, through an external shared adder.
//   clock, reset    : rising-edge clock, asynchronous active-high reset
//   start, sub      : request an operation (sampled in IDLE), 1 = A-B
//   abort           : cancel a running operation
//   op_a, op_b      : operands, captured when start is accepted
//   adder           : master side of the shared-adder bus
//   busy, done      : high in RUN / one-cycle pulse when result is valid
//   result, cout    : assembled result and final carry (1 = no borrow on sub)
//   zero            : result equals zero
module adder_sequencer
   import adder_sequencer_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int WORDS  = WORDS_DEF
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      sub,
   input  logic                      abort,
   input  logic [WORD_W*WORDS-1:0]   op_a,
   input  logic [WORD_W*WORDS-1:0]   op_b,
   adder_sequencer_if.master         adder,
   output logic                      busy,
   output logic                      done,
   output logic [WORD_W*WORDS-1:0]   result,
   output logic                      cout,
   output logic                      zero
);

   localparam int N   = WORD_W * WORDS;
   localparam int K_W = index_width(WORDS);
   localparam logic [K_W-1:0] K_LAST = K_W'(WORDS - 1);

   seq_state_t     state;
   seq_state_t     state_next;
   logic [K_W-1:0] k;
   logic [N-1:0]   cap_a;
   logic [N-1:0]   cap_b;
   logic [N-1:0]   result_next;
   logic           carry;
   logic           accept;
   logic           last_pass;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Abort takes priority over completion, so an abort on the final pass
   // still suppresses the done pulse.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      accept     = 1'b0;
      last_pass  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (abort) begin
               state_next = IDLE;
            end else if (k == K_LAST) begin
               last_pass  = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // The adder bus is idle-zero outside RUN so the shared adder sees a quiet
   // input when this block is not using it.
   always_comb begin
      adder.add_a   = '0;
      adder.add_b   = '0;
      adder.add_cin = 1'b0;
      if (state == RUN) begin
         adder.add_cin = carry;
         for (int w = 0; w < WORDS; w++) begin
            if (k == K_W'(w)) begin
               adder.add_a = cap_a[w*WORD_W +: WORD_W];
               adder.add_b = cap_b[w*WORD_W +: WORD_W];
            end
         end
      end
   end

   // Kept separate from the bus drive so the path through the external
   // adder is not seen as a loop inside one block.
   always_comb begin
      result_next = result;
      for (int w = 0; w < WORDS; w++) begin
         if (k == K_W'(w)) begin
            result_next[w*WORD_W +: WORD_W] = adder.add_sum;
         end
      end
   end

   // Subtraction is A + ~B + 1: B is inverted at capture and the carry flop
   // is preloaded with sub to supply the +1 on the first pass.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         k      <= '0;
         carry  <= 1'b0;
         cap_a  <= '0;
         cap_b  <= '0;
         result <= '0;
         cout   <= 1'b0;
         zero   <= 1'b0;
      end else if (accept) begin
         cap_a <= op_a;
         cap_b <= sub ? ~op_b : op_b;
         k     <= '0;
         carry <= sub;
      end else if (state == RUN) begin
         if (abort) begin
            k      <= '0;
            carry  <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            zero   <= 1'b0;
         end else begin
            result <= result_next;
            carry  <= adder.add_cout;
            k      <= k + K_W'(1);
            if (last_pass) begin
               k    <= '0;
               cout <= adder.add_cout;
               zero <= (result_next == '0);
            end
         end
      end
   end

endmodule

// File: tb/tb_adder_sequencer.sv
// tb_adder_sequencer
// Self-checking bench for adder_sequencer with default parameters. A simple
// word adder answers the shared-adder bus; expected results come from plain
// N-bit arithmetic on the operands.
module tb_adder_sequencer;

   localparam int WORD_W = 32;
   localparam int WORDS  = 4;
   localparam int N      = WORD_W * WORDS;

   logic         clock;
   logic         reset;
   logic         start;
   logic         sub;
   logic         abort;
   logic [N-1:0] op_a;
   logic [N-1:0] op_b;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
   logic         cout;
   logic         zero;

   int checks = 0;
   int errors = 0;

   adder_sequencer_if #(.WORD_W(WORD_W)) bus ();

   adder_sequencer #(
      .WORD_W(WORD_W),
      .WORDS (WORDS)
   ) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .sub   (sub),
      .abort (abort),
      .op_a  (op_a),
      .op_b  (op_b),
      .adder (bus),
      .busy  (busy),
      .done  (done),
      .result(result),
      .cout  (cout),
      .zero  (zero)
   );

   // Stand-in for the parent's shared word adder.
   assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b}
                                      + {{WORD_W{1'b0}}, bus.add_cin};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Full-width reference: subtraction carry means "no borrow", i.e. a >= b.
   function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                        input logic s);
      logic [N-1:0] diff;
      logic         no_borrow;
      if (s) begin
         diff      = a - b;
         no_borrow = (a >= b);
         return {no_borrow, diff};
      end
      return {1'b0, a} + {1'b0, b};
   endfunction

   function automatic logic [N-1:0] rnd_operand();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic check_output(input string tag, input logic [N-1:0] observed,
                               input logic [N-1:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Accepts an operation on the next edge and checks the first pass presented
   // to the adder.
   task automatic apply_stimulus(input string tag, input logic [N-1:0] a,
                                 input logic [N-1:0] b, input logic s, input logic ab);
      logic [WORD_W-1:0] b0;
      @(negedge clock);
      op_a  = a;
      op_b  = b;
      sub   = s;
      start = 1'b1;
      abort = ab;
      @(negedge clock);
      start = 1'b0;
      abort = 1'b0;
      b0 = b[WORD_W-1:0];
      if (s) b0 = ~b0;
      check_output({tag, " busy_run"}, N'(busy), N'(1'b1));
      check_output({tag, " add_a_w0"}, N'(bus.add_a), N'(a[WORD_W-1:0]));
      check_output({tag, " add_b_w0"}, N'(bus.add_b), N'(b0));
      check_output({tag, " add_cin_w0"}, N'(bus.add_cin), N'(s));
   endtask

   // Watches a bounded window after acceptance while scrambling the operand
   // inputs. start_at/abort_at pulse those inputs during cycle i (0 = never).
   task automatic wait_done(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic s, input int start_at, input int abort_at,
                            input bit expect_done);
      logic [N:0] expv;
      int first;
      int count;
      expv  = model(a, b, s);
      first = 0;
      count = 0;
      for (int i = 1; i <= WORDS + 3; i++) begin
         @(negedge clock);
         if (done === 1'b1) begin
            count++;
            if (first == 0) first = i;
         end
         op_a  = rnd_operand();
         op_b  = rnd_operand();
         sub   = 1'($urandom_range(0, 1));
         start = (i == start_at);
         abort = (i == abort_at);
      end
      start = 1'b0;
      abort = 1'b0;
      if (expect_done) begin
         check_output({tag, " done_cycle"}, N'(first), N'(WORDS));
         check_output({tag, " done_count"}, N'(count), N'(1));
         check_output({tag, " result"}, result, expv[N-1:0]);
         check_output({tag, " cout"}, N'(cout), N'(expv[N]));
         check_output({tag, " zero"}, N'(zero), N'(expv[N-1:0] == '0));
      end else begin
         check_output({tag, " done_count"}, N'(count), N'(0));
         check_output({tag, " result"}, result, '0);
         check_output({tag, " cout"}, N'(cout), N'(0));
         check_output({tag, " zero"}, N'(zero), N'(0));
      end
      check_output({tag, " busy_idle"}, N'(busy), N'(0));
      check_output({tag, " add_a_idle"}, N'(bus.add_a), N'(0));
   endtask

   initial begin
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         s;
      int           count;

      reset = 1'b1;
      start = 1'b0;
      sub   = 1'b0;
      abort = 1'b0;
      op_a  = '0;
      op_b  = '0;
      #12;
      check_output("rst busy", N'(busy), N'(0));
      check_output("rst done", N'(done), N'(0));
      check_output("rst result", result, '0);
      check_output("rst cout", N'(cout), N'(0));
      check_output("rst zero", N'(zero), N'(0));
      check_output("rst add_a", N'(bus.add_a), N'(0));
      check_output("rst add_b", N'(bus.add_b), N'(0));
      check_output("rst add_cin", N'(bus.add_cin), N'(0));
      @(negedge clock);
      reset = 1'b0;

      $display("[TB] all-ones plus one");
      a = '1;
      b = N'(1);
      apply_stimulus("ones_p1", a, b, 1'b0, 1'b0);
      wait_done("ones_p1", a, b, 1'b0, 0, 0, 1'b1);

      // Result flags must survive idle cycles and an abort outside RUN.
      repeat (2) @(negedge clock);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      @(negedge clock);
      check_output("hold result", result, '0);
      check_output("hold cout", N'(cout), N'(1));
      check_output("hold zero", N'(zero), N'(1));
      check_output("hold busy", N'(busy), N'(0));

      $display("[TB] 5 minus 3");
      apply_stimulus("sub_5_3", N'(5), N'(3), 1'b1, 1'b0);
      wait_done("sub_5_3", N'(5), N'(3), 1'b1, 0, 0, 1'b1);

      $display("[TB] 0 minus 1");
      apply_stimulus("sub_0_1", '0, N'(1), 1'b1, 1'b0);
      wait_done("sub_0_1", '0, N'(1), 1'b1, 0, 0, 1'b1);

      $display("[TB] start during RUN ignored");
      a = rnd_operand();
      b = rnd_operand();
      apply_stimulus("restart", a, b, 1'b0, 1'b0);
      wait_done("restart", a, b, 1'b0, 1, 0, 1'b1);

      $display("[TB] abort in third RUN cycle");
      a = rnd_operand();
      b = rnd_operand();
      apply_stimulus("abort", a, b, 1'b1, 1'b0);
      wait_done("abort", a, b, 1'b1, 0, 2, 1'b0);
      a = rnd_operand();
      b = rnd_operand();
      apply_stimulus("post_abort", a, b, 1'b1, 1'b0);
      wait_done("post_abort", a, b, 1'b1, 0, 0, 1'b1);

      $display("[TB] start with abort in IDLE, abort in DONE");
      a = rnd_operand();
      b = rnd_operand();
      apply_stimulus("start_abort", a, b, 1'b0, 1'b1);
      wait_done("start_abort", a, b, 1'b0, 0, WORDS, 1'b1);

      $display("[TB] random operations");
      for (int n = 0; n < 8; n++) begin
         a = rnd_operand();
         b = (n == 3) ? a : rnd_operand();
         s = 1'($urandom_range(0, 1));
         apply_stimulus($sformatf("rand%0d", n), a, b, s, 1'b0);
         wait_done($sformatf("rand%0d", n), a, b, s, 0, 0, 1'b1);
      end

      $display("[TB] asynchronous reset mid-RUN");
      a = rnd_operand();
      b = rnd_operand();
      apply_stimulus("areset", a, b, 1'b0, 1'b0);
      @(negedge clock);
      #2;
      reset = 1'b1;
      #1;
      check_output("areset busy", N'(busy), N'(0));
      check_output("areset done", N'(done), N'(0));
      check_output("areset result", result, '0);
      check_output("areset cout", N'(cout), N'(0));
      check_output("areset zero", N'(zero), N'(0));
      check_output("areset add_a", N'(bus.add_a), N'(0));
      check_output("areset add_cin", N'(bus.add_cin), N'(0));
      @(negedge clock);
      reset = 1'b0;
      count = 0;
      for (int i = 0; i < WORDS + 2; i++) begin
         @(negedge clock);
         if (done === 1'b1) count++;
      end
      check_output("areset no_done", N'(count), N'(0));
      check_output("areset idle", N'(busy), N'(0));

      a = rnd_operand();
      b = rnd_operand();
      apply_stimulus("post_reset", a, b, 1'b1, 1'b0);
      wait_done("post_reset", a, b, 1'b1, 0, 0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/adder_sequencer.md
ADDER_SEQUENCER -- requirements
Module: adder_sequencer

Interface
REQ-001 Parameter WORD_W, default 32, width of one shared-adder pass.
REQ-002 Parameter WORDS, default 4, passes per operation; operand width N = WORD_W*WORDS.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request new operation; sampled only in IDLE.
REQ-006 sub  input  1  0 = A+B, 1 = A-B; captured with start.
REQ-007 abort  input  1  synchronous cancel of a running operation.
REQ-008 op_a, op_b  input  N  operands; captured on the accepted start edge.
REQ-009 add_a, add_b  output  WORD_W  current word fed to the external shared adder.
REQ-010 add_cin  output  1  carry-in to the shared adder.
REQ-011 add_sum  input  WORD_W  combinational sum returned by the adder.
REQ-012 add_cout  input  1  combinational carry-out returned by the adder.
REQ-013 busy  output  1  high in RUN.
REQ-014 done  output  1  one-cycle pulse when result is valid.
REQ-015 result  output  N  assembled sum/difference.
REQ-016 cout  output  1  final carry; for sub, 1 = no borrow.
REQ-017 zero  output  1  result equals zero; valid when done pulses and held afterwards.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DONE.
REQ-019 IDLE with start=1 SHALL capture op_a, op_b (op_b bitwise inverted when sub=1), clear word index k to 0, load carry flop with sub, and enter RUN.
REQ-020 In RUN, add_a/add_b SHALL be word k of the captured operands (LSW first) and add_cin SHALL be the carry flop.
REQ-021 Each RUN edge SHALL write add_sum into result word k, write add_cout into the carry flop, and increment k.
REQ-022 When k = WORDS-1 on a RUN edge, the FSM SHALL enter DONE; RUN lasts exactly WORDS cycles.
REQ-023 DONE SHALL assert done for exactly one cycle, present final cout and zero, then return to IDLE.
REQ-024 Latency SHALL be: start accepted on edge 0, done high during the cycle after edge WORDS.
REQ-025 result, cout and zero SHALL hold their values in IDLE until the next accepted start.
REQ-026 start while RUN or DONE SHALL be ignored, with no queuing.
REQ-027 abort in RUN SHALL return to IDLE on the next edge without a done pulse, and SHALL clear result, cout and zero.
REQ-028 abort outside RUN SHALL have no effect.
REQ-029 Simultaneous start and abort in IDLE SHALL start the operation.
REQ-030 Outside RUN, add_a, add_b and add_cin SHALL be driven to 0.
REQ-031 Changes on op_a, op_b or sub after capture SHALL not affect the running operation.

Reset
REQ-032 reset SHALL force IDLE, k=0, carry=0, busy=0, done=0, result=0, cout=0, zero=0, captured operands=0, asynchronously and regardless of state.
REQ-033 Reset deasserted mid-operation SHALL leave the block in IDLE with no done pulse.

Structure
REQ-034 State encoding (IDLE/RUN/DONE) and the default WORD_W/WORDS constants SHALL live in the shared processor package.
REQ-035 The block SHALL contain no adder; the existing 32-bit CLA adder is instantiated by the parent and connected through the add_* ports.
REQ-036 No sub-module is required; the FSM, word counter, carry flop and result register are implemented inline.

Verification
REQ-037 Default parameters, a=all-ones, b=1, add -> result 0, cout 1, zero 1; carry ripples through all four passes; done on cycle 5.
REQ-038 a=0x...0005, b=0x...0003, sub -> result 2, cout 1, zero 0.
REQ-039 a=0, b=1, sub -> result all-ones (128 bits), cout 0 (borrow), zero 0.
REQ-040 start pulsed again during the 2nd RUN cycle with different operands -> ignored; the original result completes with a single done pulse.
REQ-041 abort during the 3rd RUN cycle -> IDLE next cycle, no done, result 0; a following start completes normally.
REQ-042 reset asserted asynchronously mid-RUN -> all outputs 0 immediately; no done after release.
